// File: rtl/md_unit_if.sv
// Multiply/divide unit bus: operation request from the Ex decoder plus
// HI/LO state and busy status returned to the pipeline.
interface md_unit_if;
  logic [3:0]  md_op;
  logic        start;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        busy;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic [31:0] rd_data;

  modport master (
    output md_op, start, op_a, op_b,
    input  busy, hi_q, lo_q, rd_data
  );

  modport slave (
    input  md_op, start, op_a, op_b,
    output busy, hi_q, lo_q, rd_data
  );
endinterface

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO; serves mthi/mtlo/mfhi/mflo.
// Define MD_MADD_EN to enable madd/maddu/msub/msubu (ops 9-12).
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic     clk,
  input logic     reset,
  md_unit_if.slave mdBus
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;
`ifdef MD_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd9;
  localparam logic [3:0] OP_MADDU = 4'd10;
  localparam logic [3:0] OP_MSUB  = 4'd11;
  localparam logic [3:0] OP_MSUBU = 4'd12;
`endif

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  typedef enum logic {IDLE, RUN} stateT;

  stateT             state, nextState;
  logic [CNT_W-1:0]  cnt;
  logic [31:0]       hiReg, loReg;
  logic [31:0]       res_hi, res_lo;
  logic              skipCommit;

  logic              accept;
  logic [63:0]       startRes;
  logic [CNT_W-1:0]  startCnt;
  logic              divZero;

  logic [31:0] opA, opB, bSafe;
  logic [63:0] prodS, prodU;
  logic [31:0] aMag, bMag, qMag, rMag, qS, rS, qU, rU;
`ifdef MD_MADD_EN
  logic [63:0] accIn;
`endif

  assign opA = mdBus.op_a;
  assign opB = mdBus.op_b;

  // Signed divide is done on magnitudes so the most-negative dividend needs no
  // special case: its magnitude is representable unsigned and the quotient wraps.
  always_comb begin
    bSafe = (opB == 32'd0) ? 32'd1 : opB;
    prodS = {{32{opA[31]}}, opA} * {{32{opB[31]}}, opB};
    prodU = {32'd0, opA} * {32'd0, opB};
    aMag  = opA[31] ? (32'd0 - opA) : opA;
    bMag  = bSafe[31] ? (32'd0 - bSafe) : bSafe;
    qMag  = aMag / bMag;
    rMag  = aMag % bMag;
    qS    = (opA[31] ^ bSafe[31]) ? (32'd0 - qMag) : qMag;
    rS    = opA[31] ? (32'd0 - rMag) : rMag;
    qU    = opA / bSafe;
    rU    = opA % bSafe;
  end

  always_comb begin
    accept   = 1'b0;
    startRes = 64'd0;
    startCnt = CNT_W'(MULT_CYCLES);
    divZero  = 1'b0;
`ifdef MD_MADD_EN
    accIn    = {hiReg, loReg};
`endif
    case (mdBus.md_op)
      OP_MULT:  begin accept = 1'b1; startRes = prodS; end
      OP_MULTU: begin accept = 1'b1; startRes = prodU; end
      OP_DIV: begin
        accept   = 1'b1;
        startRes = {rS, qS};
        startCnt = CNT_W'(DIV_CYCLES);
        divZero  = (opB == 32'd0);
      end
      OP_DIVU: begin
        accept   = 1'b1;
        startRes = {rU, qU};
        startCnt = CNT_W'(DIV_CYCLES);
        divZero  = (opB == 32'd0);
      end
`ifdef MD_MADD_EN
      OP_MADD:  begin accept = 1'b1; startRes = accIn + prodS; end
      OP_MADDU: begin accept = 1'b1; startRes = accIn + prodU; end
      OP_MSUB:  begin accept = 1'b1; startRes = accIn - prodS; end
      OP_MSUBU: begin accept = 1'b1; startRes = accIn - prodU; end
`endif
      default: ;
    endcase
    accept = accept & mdBus.start;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE: if (accept) nextState = RUN;
      RUN:  if (cnt == CNT_W'(1)) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // The result is computed at start and only copied into HI/LO on the final
  // edge, so a divide by zero just suppresses that copy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      hiReg      <= 32'd0;
      loReg      <= 32'd0;
      res_hi     <= 32'd0;
      res_lo     <= 32'd0;
      skipCommit <= 1'b0;
    end else begin
      state <= nextState;
      if (state == IDLE) begin
        if (accept) begin
          res_hi     <= startRes[63:32];
          res_lo     <= startRes[31:0];
          skipCommit <= divZero;
          cnt        <= startCnt;
        end else if (mdBus.md_op == OP_MTHI) begin
          hiReg <= opA;
        end else if (mdBus.md_op == OP_MTLO) begin
          loReg <= opA;
        end
      end else begin
        if (cnt == CNT_W'(1)) begin
          cnt <= '0;
          if (!skipCommit) begin
            hiReg <= res_hi;
            loReg <= res_lo;
          end
        end else begin
          cnt <= cnt - CNT_W'(1);
        end
      end
    end
  end

  assign mdBus.busy    = (state == RUN);
  assign mdBus.hi_q    = hiReg;
  assign mdBus.lo_q    = loReg;
  assign mdBus.rd_data = (mdBus.md_op == OP_MFHI) ? hiReg :
                         (mdBus.md_op == OP_MFLO) ? loReg : 32'd0;

endmodule
